score_max_collector: RTL and testbench
======================================

// Module: score_max_collector
// PURPOSE
//  Consumes the per-cycle V outputs of the PE array (`PE_Array_size lanes of `V_E_F_Bit) and
//  reduces them into the best local-alignment score of one query/database job. Pipelined
//  2-level max tree (64->8->1) feeds a running-max accumulator; one result is reported per job.
//  Sits directly downstream of the PE array, upstream of the result/host interface.
// PARAMETERS
//  DATA_WIDTH  `V_E_F_Bit (17)   score width, MSB = sign, DATA_WIDTH-1 magnitude bits
//  LANES       `PE_Array_size(64) PE lanes per beat; fixed at 64 (8x8 tree)
// PORTS
//  clk        in   1                 clock, all state on posedge
//  rst_n      in   1                 asynchronous active-low reset
//  i_clear    in   1                 sync abort: drop in-flight beats, clear accumulator
//  i_valid    in   1                 i_data beat valid (no backpressure; always accepted)
//  i_last     in   1                 qualifies final beat of current job (ignored if !i_valid)
//  i_data     in   LANES*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//  o_busy     out  1                 job open or beats in pipe
//  o_valid    out  1                 1-cycle pulse, o_score holds job result
//  o_score    out  DATA_WIDTH        job maximum, held until next o_valid
// BEHAVIOUR
//  - Reset: o_valid=0, o_score=0, o_busy=0, state=IDLE, all pipe valids=0, acc=0.
//  - Compare rule (team max semantics): if exactly one operand negative, take the other; both
//    non-negative: larger magnitude, tie -> first operand; both negative -> 0. Result never negative.
//  - S1 (reg): 8 groups of 8 lanes -> 8 partial maxima; valid/last carried alongside.
//  - S2 (reg): 8 partials -> beat max.
//  - S3 (reg): acc <= (state==IDLE) ? beat_max : max(acc, beat_max).
//  - Latency: i_last beat at cycle N -> o_valid=1 at N+3, o_score=max over all job beats.
//  - FSM on S2 output: IDLE --S2 valid & !last--> ACCUM; ACCUM --S2 valid & last--> IDLE;
//    IDLE --S2 valid & last--> IDLE (single-beat job). Result registered on any S2 last.
//  - Back-to-back jobs: beat after an i_last starts a new job with no bubble; acc reseeds.
//  - Gaps (i_valid=0) mid-job: acc/state hold.
//  - i_clear: S1/S2 valids and lasts cleared, state->IDLE, acc->0 next cycle; o_score unchanged;
//    an o_valid due in the same cycle is suppressed. Beat presented with i_clear is dropped.
//  - o_busy = (state==ACCUM) | S1 valid | S2 valid.
//  - Reset mid-job: everything returns to reset values immediately (async).
// CONFIGURATION
//  SCORE_POS_EN defined: extra output o_beat [15:0] = 0-based beat index within the job where
//  the winning maximum first occurred (ties keep earlier beat); beat counter rides the pipe,
//  zero at reset/clear/new job; 0 at reset. Undefined: port and counter absent; o_score only.
// STRUCTURE
//  - Shared package/include: DATA_WIDTH, LANES, `PE_Array_size; the shared max modules
//    (2-input, 4-input, 8-input) are reused, not re-implemented.
//  - Sub-module: max_tree_stage (8-way max + valid/last/beat-tag register) instanced 8x in S1,
//    1x in S2.
// TESTING
//  1 Single beat, lane 37=100, others 5, i_last=1 -> o_valid at +3, o_score=100.
//  2 Job of 4 beats, beat maxima 7,300,300,12 -> o_score=300; SCORE_POS_EN: o_beat=1.
//  3 All lanes negative (sign=1) across 3 beats -> o_score=0; mixed +4/-9 -> 4.
//  4 Back-to-back jobs A(max 50, 2 beats) then B(max 20, 1 beat), no gap -> pulses 50 then 20,
//    one cycle apart; B does not inherit A's max.
//  5 i_clear asserted 1 cycle after A's i_last beat -> no o_valid for A, o_busy=0, o_score unchanged.
//  6 rst_n low mid-job (2 beats in pipe) -> all outputs 0 asynchronously; new job after release
//    reports only its own max.

Source files
------------

// File: rtl/score_max_collector_pkg.sv
// Shared constants, types and max helpers for score_max_collector.
// Team max semantics: a negative operand loses to a non-negative one, two
// non-negatives keep the larger magnitude (tie -> first operand), two negatives
// give 0. The result is therefore never negative.
// The 2/4/8-input reductions below are the single max implementation; every
// tree level calls them.
package score_max_collector_pkg;

    localparam int unsigned PE_ARRAY_SIZE = 64;
    localparam int unsigned DATA_WIDTH    = 17;
    localparam int unsigned LANES         = PE_ARRAY_SIZE;
    localparam int unsigned GROUP         = 8;
    localparam int unsigned NUM_GROUPS    = LANES / GROUP;
    localparam int unsigned BEAT_W        = 16;

    typedef logic [DATA_WIDTH-1:0] score_t;

    typedef enum logic {StIdle, StAccum} state_e;

    function automatic score_t max2(input score_t a, input score_t b);
        if (a[DATA_WIDTH-1] && b[DATA_WIDTH-1]) return '0;
        if (a[DATA_WIDTH-1]) return b;
        if (b[DATA_WIDTH-1]) return a;
        return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
    endfunction

    function automatic score_t max4(input logic [4*DATA_WIDTH-1:0] v);
        return max2(max2(v[0 +: DATA_WIDTH], v[DATA_WIDTH +: DATA_WIDTH]),
                    max2(v[2*DATA_WIDTH +: DATA_WIDTH], v[3*DATA_WIDTH +: DATA_WIDTH]));
    endfunction

    function automatic score_t max8(input logic [8*DATA_WIDTH-1:0] v);
        return max2(max4(v[0 +: 4*DATA_WIDTH]), max4(v[4*DATA_WIDTH +: 4*DATA_WIDTH]));
    endfunction

endpackage

// File: rtl/score_max_collector_if.sv
// Beat/result bus of score_max_collector.
//   master: drives i_clear, i_valid, i_last, i_data; observes o_busy, o_valid, o_score
//   slave : the collector itself
// SCORE_POS_EN adds o_beat (beat index of the winning maximum).
interface score_max_collector_if;
    import score_max_collector_pkg::*;

    logic                        i_clear;
    logic                        i_valid;
    logic                        i_last;
    logic [LANES*DATA_WIDTH-1:0] i_data;
    logic                        o_busy;
    logic                        o_valid;
    score_t                      o_score;
`ifdef SCORE_POS_EN
    logic [BEAT_W-1:0]           o_beat;
`endif

    modport master (
        output i_clear, i_valid, i_last, i_data,
        input  o_busy, o_valid, o_score
`ifdef SCORE_POS_EN
        , o_beat
`endif
    );

    modport slave (
        input  i_clear, i_valid, i_last, i_data,
        output o_busy, o_valid, o_score
`ifdef SCORE_POS_EN
        , o_beat
`endif
    );

endinterface

// File: rtl/score_max_collector_max_tree_stage.sv
// One registered 8-way max-tree stage: reduces 8 scores to one and carries
// valid/last (and, with SCORE_POS_EN, the beat tag) alongside.
// Ports: clk, rst_n (async active-low), clear_i (drops the beat), valid_i,
//        last_i, tag_i, data_i (8 packed scores) -> valid_o, last_o, max_o, tag_o.
module score_max_collector_max_tree_stage
    import score_max_collector_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        valid_i,
    input  logic                        last_i,
`ifdef SCORE_POS_EN
    input  logic [BEAT_W-1:0]           tag_i,
    output logic [BEAT_W-1:0]           tag_o,
`endif
    input  logic [GROUP*DATA_WIDTH-1:0] data_i,
    output logic                        valid_o,
    output logic                        last_o,
    output score_t                      max_o
);

    logic   valid_q, last_q;
    score_t max_q;
    logic   take;

    assign take = valid_i & ~clear_i;

`ifdef SCORE_POS_EN
    logic [BEAT_W-1:0] tag_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (take) begin
            tag_q <= tag_i;
        end
    end
    assign tag_o = tag_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            max_q   <= '0;
        end else begin
            valid_q <= take;
            last_q  <= take & last_i;
            if (take) begin
                max_q <= max8(data_i);
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign max_o   = max_q;

endmodule

// File: rtl/score_max_collector.sv
// Reduces 64-lane PE-array beats into the best score of one job.
// S1: 8 x 8-way max, S2: 8-way max of partials, S3: running-max accumulator
// plus IDLE/ACCUM job FSM with registered result. o_valid pulses 3 cycles
// after the last beat is presented.
// Ports: clk, rst_n (async active-low), bus (score_max_collector_if.slave).
// Optional macro SCORE_POS_EN: adds bus.o_beat, the first beat index of the max.
module score_max_collector
    import score_max_collector_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    score_max_collector_if.slave  bus
);

    logic [NUM_GROUPS-1:0]            s1_valid_v, s1_last_v;
    logic [NUM_GROUPS*DATA_WIDTH-1:0] s1_max;
    logic                             s1_valid, s1_last;
    logic                             s2_valid, s2_last;
    score_t                           s2_max;

    state_e state_q;
    score_t acc_q, acc_d;
    logic   o_valid_q;
    score_t o_score_q;

`ifdef SCORE_POS_EN
    logic [BEAT_W-1:0] in_beat_q;
    logic [BEAT_W-1:0] s1_tag_v [NUM_GROUPS];
    logic [BEAT_W-1:0] s1_tag, s2_tag;
    logic [BEAT_W-1:0] best_beat_q, beat_d, o_beat_q;

    // Beat index within the current job at the pipe input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_beat_q <= '0;
        end else if (bus.i_clear) begin
            in_beat_q <= '0;
        end else if (bus.i_valid) begin
            in_beat_q <= bus.i_last ? '0 : in_beat_q + 1'b1;
        end
    end
`endif

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_s1
        score_max_collector_max_tree_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (bus.i_clear),
            .valid_i (bus.i_valid),
            .last_i  (bus.i_last),
`ifdef SCORE_POS_EN
            .tag_i   (in_beat_q),
            .tag_o   (s1_tag_v[g]),
`endif
            .data_i  (bus.i_data[g*GROUP*DATA_WIDTH +: GROUP*DATA_WIDTH]),
            .valid_o (s1_valid_v[g]),
            .last_o  (s1_last_v[g]),
            .max_o   (s1_max[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // All S1 copies of the control fields are identical; OR-merge them.
    always_comb begin
        s1_valid = |s1_valid_v;
        s1_last  = |s1_last_v;
`ifdef SCORE_POS_EN
        s1_tag = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            s1_tag |= s1_tag_v[g];
        end
`endif
    end

    score_max_collector_max_tree_stage u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (bus.i_clear),
        .valid_i (s1_valid),
        .last_i  (s1_last),
`ifdef SCORE_POS_EN
        .tag_i   (s1_tag),
        .tag_o   (s2_tag),
`endif
        .data_i  (s1_max),
        .valid_o (s2_valid),
        .last_o  (s2_last),
        .max_o   (s2_max)
    );

    // First beat of a job reseeds the accumulator.
    always_comb begin
        acc_d = (state_q == StIdle) ? s2_max : max2(acc_q, s2_max);
`ifdef SCORE_POS_EN
        // Strictly greater so ties keep the earlier beat.
        beat_d = ((state_q == StIdle) || (s2_max[DATA_WIDTH-2:0] > acc_q[DATA_WIDTH-2:0]))
                 ? s2_tag : best_beat_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            o_valid_q <= 1'b0;
            o_score_q <= '0;
`ifdef SCORE_POS_EN
            best_beat_q <= '0;
            o_beat_q    <= '0;
`endif
        end else begin
            o_valid_q <= 1'b0;
            if (bus.i_clear) begin
                state_q <= StIdle;
                acc_q   <= '0;
`ifdef SCORE_POS_EN
                best_beat_q <= '0;
`endif
            end else if (s2_valid) begin
                acc_q <= acc_d;
`ifdef SCORE_POS_EN
                best_beat_q <= beat_d;
`endif
                if (s2_last) begin
                    state_q   <= StIdle;
                    o_valid_q <= 1'b1;
                    o_score_q <= acc_d;
`ifdef SCORE_POS_EN
                    o_beat_q <= beat_d;
`endif
                end else begin
                    state_q <= StAccum;
                end
            end
        end
    end

    assign bus.o_busy  = (state_q == StAccum) | s1_valid | s2_valid;
    assign bus.o_valid = o_valid_q;
    assign bus.o_score = o_score_q;
`ifdef SCORE_POS_EN
    assign bus.o_beat  = o_beat_q;
`endif

endmodule

// File: tb/tb_score_max_collector.sv
// Scoreboard bench for score_max_collector: the driver queues the expected
// result and cycle for every job-ending beat, a negedge monitor pops and
// compares on each o_valid pulse.
module tb_score_max_collector;
    import score_max_collector_pkg::*;

    localparam int W = LANES * DATA_WIDTH;
    typedef logic [W-1:0] beat_t;
    typedef struct {
        int score;
        int cyc;
        int beat;
    } exp_t;

    localparam score_t NEG5 = 17'h1_0005;
    localparam score_t NEG9 = 17'h1_0009;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    score_max_collector_if bus ();

    score_max_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input score_t fill, input int lane, input score_t val);
        beat_t d;
        for (int k = 0; k < LANES; k++) begin
            d[k*DATA_WIDTH +: DATA_WIDTH] = (k == lane) ? val : fill;
        end
        return d;
    endfunction

    // Presents one beat; on a job-ending beat optionally queues the result.
    task automatic send(input beat_t d, input bit last, input bit expect_out,
                        input int exp_score, input int exp_beat);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_last  = last;
        bus.i_data  = d;
        bus.i_clear = 1'b0;
        if (last && expect_out) sb.push_back('{exp_score, cyc + 3, exp_beat});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_last  = 1'b0;
            bus.i_clear = 1'b0;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.o_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_o_valid: got pulse score %0d at cycle %0d, expected none",
                         bus.o_score, cyc);
            end else begin
                e = sb.pop_front();
                check("o_score", int'(bus.o_score), e.score);
                check("latency", cyc, e.cyc);
`ifdef SCORE_POS_EN
                check("o_beat", int'(bus.o_beat), e.beat);
`endif
            end
        end
    end

    initial begin
        bus.i_clear = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_o_valid", int'(bus.o_valid), 0);
        check("reset_o_score", int'(bus.o_score), 0);
        check("reset_o_busy", int'(bus.o_busy), 0);
        rst_n = 1'b1;
        idle(2);

        // 1: single beat job
        send(mk(17'd5, 37, 17'd100), 1'b1, 1'b1, 100, 0);
        idle(1);
        check("busy_in_flight", int'(bus.o_busy), 1);
        idle(5);

        // 2: four beats, maxima 7,300,300,12
        send(mk(17'd3, 0, 17'd7), 1'b0, 1'b0, 0, 0);
        send(mk(17'd3, 10, 17'd300), 1'b0, 1'b0, 0, 0);
        send(mk(17'd3, 63, 17'd300), 1'b0, 1'b0, 0, 0);
        send(mk(17'd3, 5, 17'd12), 1'b1, 1'b1, 300, 1);
        idle(6);

        // 3: all negative -> 0; mixed +4/-9 -> 4
        send(mk(NEG5, 0, NEG9), 1'b0, 1'b0, 0, 0);
        send(mk(NEG9, 40, NEG5), 1'b0, 1'b0, 0, 0);
        send(mk(NEG5, 7, NEG5), 1'b1, 1'b1, 0, 0);
        idle(6);
        send(mk(NEG9, 17, 17'd4), 1'b1, 1'b1, 4, 0);
        idle(6);

        // 4: back-to-back jobs A (30,50) then B (20)
        send(mk(17'd1, 2, 17'd30), 1'b0, 1'b0, 0, 0);
        send(mk(17'd1, 9, 17'd50), 1'b1, 1'b1, 50, 1);
        send(mk(17'd1, 4, 17'd20), 1'b1, 1'b1, 20, 0);
        idle(6);

        // 5: clear one cycle after the last beat suppresses the result
        send(mk(17'd1, 1, 17'd60), 1'b1, 1'b0, 0, 0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_clear = 1'b1;
        idle(1);
        check("clear_o_busy", int'(bus.o_busy), 0);
        check("clear_o_score", int'(bus.o_score), 20);
        idle(5);
        check("clear_o_score_hold", int'(bus.o_score), 20);

        // 6: async reset with two beats in the pipe
        send(mk(17'd1, 0, 17'd500), 1'b0, 1'b0, 0, 0);
        send(mk(17'd1, 0, 17'd600), 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        check("pre_reset_busy", int'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1;
        check("async_o_busy", int'(bus.o_busy), 0);
        check("async_o_score", int'(bus.o_score), 0);
        check("async_o_valid", int'(bus.o_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send(mk(17'd1, 3, 17'd40), 1'b1, 1'b1, 40, 0);
        idle(8);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
